// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning the HI/LO registers (shift-add multiply, restoring divide).
// Define MDU_SIGNED_EN to make op 100/101 signed MULT/DIV; otherwise op[2] is ignored for mult/div.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    // state | meaning
    // IDLE  | waiting for an issue
    // MUL   | shift-add multiply, one multiplier bit per cycle
    // DIV   | restoring divide, one quotient bit per cycle
    // FIN   | result just written to hi/lo, done=1; accepts a new issue
    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state, state_nx;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   a_op;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;

    logic accept, op_mul, op_div, op_mthi, op_mtlo, last;
    logic [WIDTH-1:0] x_mag, y_mag;

    assign accept  = start && (state == IDLE || state == FIN);
    assign op_mul  = (op[1:0] == 2'b00);
    assign op_div  = (op[1:0] == 2'b01);
    assign op_mthi = (op == 3'b010);
    assign op_mtlo = (op == 3'b011);
    assign busy    = (state == MUL) || (state == DIV);
    assign done    = (state == FIN);
    assign last    = busy && (count == LAST);

`ifdef MDU_SIGNED_EN
    logic x_neg, y_neg, sgn_x, sgn_y, dz;
    assign x_neg = op[2] & x[WIDTH-1];
    assign y_neg = op[2] & y[WIDTH-1];
    assign x_mag = x_neg ? -x : x;
    assign y_mag = y_neg ? -y : y;
`else
    assign x_mag = x;
    assign y_mag = y;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FIN: begin
                if (accept && op_mul)      state_nx = MUL;
                else if (accept && op_div) state_nx = DIV;
                else                       state_nx = IDLE;
            end
            MUL, DIV: if (count == LAST) state_nx = FIN;
            default:  state_nx = IDLE;
        endcase
    end

    // Multiplier sits in the low half of acc and is consumed LSB first.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_op} : '0);
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

    // Dividend sits in acc low half; quotient bits shift in behind it.
    logic [WIDTH+1:0] div_sh, div_diff;
    logic             div_ok;
    logic [WIDTH:0]   rem_nx;
    logic [WIDTH-1:0] quo_nx;
    assign div_sh   = {rem, acc[WIDTH-1]};
    assign div_diff = div_sh - {2'b00, a_op};
    assign div_ok   = ~div_diff[WIDTH+1];
    assign rem_nx   = div_ok ? div_diff[WIDTH:0] : div_sh[WIDTH:0];
    assign quo_nx   = {acc[WIDTH-2:0], div_ok};

    logic [WIDTH-1:0] res_hi, res_lo;
    always_comb begin
        res_hi = rem_nx[WIDTH-1:0];
        res_lo = quo_nx;
        if (state == MUL) {res_hi, res_lo} = mul_nx;
`ifdef MDU_SIGNED_EN
        if (state == MUL && (sgn_x ^ sgn_y)) {res_hi, res_lo} = -mul_nx;
        // Divide by zero keeps the raw all-ones quotient and dividend magnitude.
        if (state == DIV && !dz) begin
            if (sgn_x ^ sgn_y) res_lo = -quo_nx;
            if (sgn_x)         res_hi = -rem_nx[WIDTH-1:0];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            a_op  <= '0;
            acc   <= '0;
            rem   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (state == MUL) begin
                acc   <= mul_nx;
                count <= count + CW'(1);
            end else if (state == DIV) begin
                acc   <= {acc[2*WIDTH-1:WIDTH], quo_nx};
                rem   <= rem_nx;
                count <= count + CW'(1);
            end
            if (last) begin
                hi    <= res_hi;
                lo    <= res_lo;
                count <= '0;
            end
            if (accept) begin
                if (op_mul) begin
                    a_op  <= x_mag;
                    acc   <= {{WIDTH{1'b0}}, y_mag};
                    count <= '0;
                end else if (op_div) begin
                    a_op  <= y_mag;
                    acc   <= {{WIDTH{1'b0}}, x_mag};
                    rem   <= '0;
                    count <= '0;
                end else if (op_mthi) begin
                    hi <= x;
                end else if (op_mtlo) begin
                    lo <= x;
                end
            end
        end
    end

`ifdef MDU_SIGNED_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sgn_x <= 1'b0;
            sgn_y <= 1'b0;
            dz    <= 1'b0;
        end else if (accept && (op_mul || op_div)) begin
            sgn_x <= x_neg;
            sgn_y <= y_neg;
            dz    <= (y == '0);
        end
    end
`endif

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: issued mult/div results are queued, a monitor checks them on done.
module tb_mdu_hilo;
    localparam int W = 32;

    logic         clk, rst_n, start;
    logic [2:0]   op;
    logic [W-1:0] x, y;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    mdu_hilo #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .x(x), .y(y),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int n_push = 0;
    int n_done = 0;
    logic [63:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            n_done++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: hi=%h lo=%h with empty queue", hi, lo);
            end else begin
                chk("result", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Called at a negedge; the op is sampled at the following posedge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        start = 1'b1; op = o; x = a; y = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic expect_res(input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_q.push_back({eh, el});
        n_push++;
    endtask

    // Returns at the first negedge with busy low (the FIN cycle of a mult/div).
    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 200);
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL timeout: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    initial begin
        int cnt, d0;
        rst_n = 1'b1; start = 1'b0; op = '0; x = '0; y = '0;
        #2 rst_n = 1'b0;
        #1 chk("reset_state", {30'd0, busy, done, hi}, 64'd0);
        chk("reset_lo", {32'd0, lo}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // MULTU all-ones squared, busy length and single done
        d0 = n_done;
        expect_res(32'hFFFF_FFFE, 32'h0000_0001);
        issue(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        cnt = 0;
        do begin
            @(negedge clk);
            if (busy) cnt++;
        end while (busy && cnt < 200);
        chk("busy_cycles", 64'(cnt), 64'd32);
        @(negedge clk);
        chk("done_pulses", 64'(n_done - d0), 64'd1);

        // DIVU, then a back-to-back divide-by-zero accepted in FIN
        expect_res(32'd2, 32'd14);
        issue(3'b001, 32'd100, 32'd7);
        wait_idle();
        expect_res(32'd100, 32'hFFFF_FFFF);
        issue(3'b001, 32'd100, 32'd0);
        chk("fin_accept_busy", {63'd0, busy}, 64'd1);
        wait_idle();
        @(negedge clk);

        // Starts while busy are ignored
        expect_res(32'd3, 32'd0);
        issue(3'b000, 32'h0001_0000, 32'h0003_0000);
        repeat (4) @(negedge clk);
        issue(3'b001, 32'd9, 32'd3);
        @(negedge clk);
        issue(3'b010, 32'h55, 32'd0);
        @(negedge clk);
        chk("hold_while_busy", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
        wait_idle();
        @(negedge clk);
        chk("after_ignored", {hi, lo}, {32'd3, 32'd0});
        chk("idle_after", {62'd0, busy, done}, 64'd0);

        // MTHI / MTLO / reserved op
        issue(3'b010, 32'h0000_A5A5, 32'd0);
        chk("mthi_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        chk("mthi", {hi, lo}, {32'h0000_A5A5, 32'd0});
        issue(3'b110, 32'hDEAD_BEEF, 32'd1);
        @(negedge clk);
        chk("reserved", {hi, lo, 30'd0, busy, done}, {32'h0000_A5A5, 32'd0, 32'd0});
        issue(3'b011, 32'h77, 32'd0);
        @(negedge clk);
        chk("mtlo", {hi, lo}, {32'h0000_A5A5, 32'h77});

        // Reset mid-operation: immediate clear, no later done
        issue(3'b001, 32'd50, 32'd5);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midreset", {hi, lo}, 64'd0);
        chk("midreset_flags", {62'd0, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        issue(3'b011, 32'h1234, 32'd0);
        @(negedge clk);
        chk("mtlo_after_reset", {hi, lo}, {32'd0, 32'h1234});

`ifdef MDU_SIGNED_EN
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(3'b101, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        @(negedge clk);
        expect_res(32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(3'b100, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        @(negedge clk);
        expect_res(32'd0, 32'h8000_0000);
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle();
        @(negedge clk);
`else
        expect_res(32'd1, 32'h7FFF_FFFC);
        issue(3'b101, 32'hFFFF_FFF9, 32'd2);
        wait_idle();
        @(negedge clk);
        expect_res(32'h0000_0004, 32'hFFFF_FFF1);
        issue(3'b100, 32'hFFFF_FFFD, 32'd5);
        wait_idle();
        @(negedge clk);
`endif

        @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("done_total", 64'(n_done), 64'(n_push));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
